// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin pick helper for the ROM lookup arbiter.
// The pick function works on a fixed 8-bit request vector, which covers the maximum of 8 requesters.
package rom_arb_pkg;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int MAX_REQ = 8;

  typedef logic [AW-1:0] rom_addr_t;
  typedef logic [DW-1:0] rom_data_t;

  // Search circularly from ptr for the first set request among the first n bits.
  // Returns a one-hot grant, or zero when nothing is requested.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one requester while advance is high and moves the
// priority pointer just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);
  import rom_arb_pkg::*;

  logic [IDW-1:0]     ptr_reg;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     gnt_idx;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), 32'(ptr_reg), NUM_REQ);
    gnt  = advance ? pick[NUM_REQ-1:0] : '0;
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = IDW'(i);
    end
  end

  // Explicit wrap keeps the pointer inside 0..NUM_REQ-1 for non-power-of-two counts.
  always_comb begin
    ptr_next = ptr_reg;
    if (|gnt) ptr_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/rom_lookup_arbiter.sv
// Shares one registered-read lookup ROM among NUM_REQ requesters: round-robin issue,
// one lookup in flight while the ROM reads, then a backpressured response register.
module rom_lookup_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = rom_arb_pkg::AW,
  parameter int DW      = rom_arb_pkg::DW,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_data,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy
);
  import rom_arb_pkg::*;

  logic               inflight_reg;
  logic [IDW-1:0]     inflight_id_reg;
  logic [AW-1:0]      last_addr_reg;
  logic               rsp_valid_reg;
  logic [IDW-1:0]     rsp_id_reg;
  logic [DW-1:0]      rsp_data_reg;

  logic               s2_free;
  logic               s1_moves;
  logic               can_issue;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [AW-1:0]      gnt_addr;
  logic [AW-1:0]      addr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
  end

  assign s2_free  = !rsp_valid_reg || rsp_ready;
  assign s1_moves = inflight_reg && s2_free;
  // Holding off grants during reset keeps req_ready at zero while state clears.
  assign can_issue = (!inflight_reg || s1_moves) && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (can_issue),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IDW'(i);
        gnt_addr = addr_arr[i];
      end
    end
  end

  // Outside grant cycles the ROM keeps seeing the last address, so rom_data stays valid under a stall.
  assign rom_addr  = (|gnt) ? gnt_addr : last_addr_reg;
  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = inflight_reg || rsp_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg    <= 1'b0;
      inflight_id_reg <= '0;
      last_addr_reg   <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_data_reg    <= '0;
    end else begin
      if (|gnt) begin
        inflight_reg    <= 1'b1;
        inflight_id_reg <= gnt_idx;
        last_addr_reg   <= gnt_addr;
      end else if (s1_moves) begin
        inflight_reg <= 1'b0;
      end

      if (s1_moves) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= rom_data;
        rsp_id_reg    <= inflight_id_reg;
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Directed and randomized checks of rom_lookup_arbiter (3 requesters) against a
// bench ROM holding mem[a] = a ^ 8'hA5 and a queue-based reference model.
module tb_rom_lookup_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [7:0]     a [N];
  logic [N*8-1:0] req_addr;
  logic [7:0]     rom_addr;
  logic [7:0]     rom_data;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_ready;
  logic           busy;
  logic [7:0]     mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;
  exp_t q[$];

  assign req_addr = {a[2], a[1], a[0]};

  rom_lookup_arbiter #(.NUM_REQ(N), .AW(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  always @(posedge clk) rom_data <= mem[rom_addr];

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) a[i] = 8'h00;
    tick;
    tick;
    reset = 1'b0;
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    logic [2:0] exp_gnt [4];
    logic [7:0] exp_dat [4];
    logic [1:0] exp_id  [4];
    logic [7:0] rx [$];
    int         sent;
    logic       acc;
    int         mp;
    int         g;
    logic [N-1:0] accm;
    logic       hold;
    logic [1:0] sv_id;
    logic [7:0] sv_d;
    exp_t       e;

    // Reset state, then test 1: single lookup of 0x20 by requester 0
    do_reset;
    settle;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    req_valid = 3'b001; a[0] = 8'h20;
    settle;
    chk("t1_ready", 32'(req_ready), 32'(3'b001));
    chk("t1_rom_addr", 32'(rom_addr), 32'(8'h20));
    tick;
    req_valid = '0;
    settle;
    chk("t1_rsp_early", 32'(rsp_valid), 32'(0));
    chk("t1_busy", 32'(busy), 32'(1));
    tick;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t1_rsp_id", 32'(rsp_id), 32'(0));
    chk("t1_rsp_data", 32'(rsp_data), 32'(8'h85));
    tick;
    chk("t1_rsp_once", 32'(rsp_valid), 32'(0));

    // Test 2: simultaneous requests, addresses 0x00 and 0xFF
    do_reset;
    a[0] = 8'h00; a[1] = 8'hFF;
    exp_gnt = '{3'b001, 3'b010, 3'b001, 3'b010};
    exp_dat = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
    exp_id  = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 3'b011 : 3'b000;
      settle;
      if (c < 4) chk($sformatf("t2_gnt%0d", c), 32'(req_ready), 32'(exp_gnt[c]));
      if (c >= 2) begin
        chk($sformatf("t2_rv%0d", c), 32'(rsp_valid), 32'(1));
        chk($sformatf("t2_id%0d", c), 32'(rsp_id), 32'(exp_id[c-2]));
        chk($sformatf("t2_d%0d", c), 32'(rsp_data), 32'(exp_dat[c-2]));
      end
      tick;
    end
    chk("t2_rv_end", 32'(rsp_valid), 32'(0));

    // Test 3: backpressure with requester 1 streaming 0x10..0x12
    do_reset;
    sent = 0;
    rx.delete();
    for (int c = 0; c < 10; c++) begin
      rsp_ready = (c >= 5);
      req_valid = (sent < 3) ? 3'b010 : 3'b000;
      a[1] = 8'h10 + 8'(sent);
      settle;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("t3_stall_rdy%0d", c), 32'(req_ready), 32'(0));
        chk($sformatf("t3_stall_addr%0d", c), 32'(rom_addr), 32'(8'h11));
        chk($sformatf("t3_stall_data%0d", c), 32'(rsp_data), 32'(8'hB5));
        chk($sformatf("t3_stall_rv%0d", c), 32'(rsp_valid), 32'(1));
      end
      acc = req_valid[1] && req_ready[1];
      if (rsp_valid && rsp_ready) rx.push_back(rsp_data);
      tick;
      if (acc) sent++;
    end
    chk("t3_count", 32'(rx.size()), 32'(3));
    if (rx.size() == 3) begin
      chk("t3_rx0", 32'(rx[0]), 32'(8'hB5));
      chk("t3_rx1", 32'(rx[1]), 32'(8'hB4));
      chk("t3_rx2", 32'(rx[2]), 32'(8'hB7));
    end

    // Test 4: reset the cycle after a grant of 0x33
    do_reset;
    req_valid = 3'b001; a[0] = 8'h33;
    settle;
    chk("t4_gnt", 32'(req_ready), 32'(3'b001));
    tick;
    reset = 1'b1; req_valid = '0;
    settle;
    chk("t4_rdy_in_reset", 32'(req_ready), 32'(0));
    tick;
    reset = 1'b0;
    settle;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t4_rsp_data", 32'(rsp_data), 32'(0));
    chk("t4_rsp_id", 32'(rsp_id), 32'(0));
    chk("t4_rom_addr", 32'(rom_addr), 32'(0));
    chk("t4_busy", 32'(busy), 32'(0));
    tick;
    chk("t4_no_rsp", 32'(rsp_valid), 32'(0));
    req_valid = 3'b011; a[0] = 8'h01; a[1] = 8'h02;
    settle;
    chk("t4_ptr0", 32'(req_ready), 32'(3'b001));
    tick;
    req_valid = '0;
    tick;
    tick;

    // Test 5: requester 0 always valid, requester 1 holds until granted
    do_reset;
    a[0] = 8'h01; a[1] = 8'h02;
    req_valid = 3'b001;
    for (int c = 0; c < 6; c++) begin
      settle;
      chk($sformatf("t5_subset%0d", c), 32'(req_ready & ~req_valid), 32'(0));
      if (c == 0) chk("t5_g0", 32'(req_ready), 32'(3'b001));
      if (c == 1) chk("t5_g1", 32'(req_ready), 32'(3'b010));
      if (c == 2) chk("t5_g2", 32'(req_ready), 32'(3'b001));
      accm = req_valid & req_ready;
      tick;
      req_valid = (req_valid & ~accm) | 3'b001;
      if (c == 0) req_valid[1] = 1'b1;
    end
    req_valid = '0;
    tick;
    tick;

    // Test 6: randomized valid/ready against the reference model
    do_reset;
    q.delete();
    mp   = 0;
    hold = 1'b0;
    sv_id = '0;
    sv_d  = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          a[i] = 8'($urandom_range(0, 255));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      settle;
      if (hold) begin
        chk("r_hold_v", 32'(rsp_valid), 32'(1));
        chk("r_hold_id", 32'(rsp_id), 32'(sv_id));
        chk("r_hold_d", 32'(rsp_data), 32'(sv_d));
      end
      chk("r_busy", 32'(busy), 32'(q.size() != 0));
      chk("r_subset", 32'(req_ready & ~req_valid), 32'(0));
      chk("r_onehot", 32'($onehot0(req_ready)), 32'(1));
      if (req_valid != '0 && q.size() <= 1) chk("r_progress", 32'(req_ready != '0), 32'(1));
      accm = '0;
      if (req_ready != '0) begin
        g = first_from(req_valid, mp);
        chk("r_gnt", 32'(req_ready), 32'(1) << g);
        chk("r_rom_addr", 32'(rom_addr), 32'(a[g]));
        q.push_back('{id: 2'(g), d: mem[a[g]]});
        mp = (g + 1) % N;
        accm = req_valid & req_ready;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("r_extra_rsp", 32'(1), 32'(q.size()));
        end else begin
          e = q.pop_front();
          chk("r_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("r_rsp_d", 32'(rsp_data), 32'(e.d));
        end
      end
      hold  = rsp_valid && !rsp_ready;
      sv_id = rsp_id;
      sv_d  = rsp_data;
      tick;
      req_valid = req_valid & ~accm;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("r_drain_extra", 32'(1), 32'(q.size()));
        end else begin
          e = q.pop_front();
          chk("r_drain_id", 32'(rsp_id), 32'(e.id));
          chk("r_drain_d", 32'(rsp_data), 32'(e.d));
        end
      end
      tick;
    end
    chk("r_all_returned", 32'(q.size()), 32'(0));
    chk("r_idle", 32'(busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
